mux_eval_arbiter: RTL and testbench
===================================

Name: mux_eval_arbiter

Overview:
- Shares one evaluator of f = (x1 & x2) | (~x2 & x3) among N_REQ requesters.
- Each requester presents a 3-bit operand {x1,x2,x3} under a valid/ready handshake.
- A round-robin arbiter grants at most one requester per cycle. The result is registered and returned with the requester's ID under a valid/ready response handshake.
- Sits between lab stimulus sources and any consumer of f-results, replacing per-requester copies of the gate network.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..16, non-power-of-2 allowed.
- ID_W, $clog2(N_REQ), width of the requester ID; derived, not overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req_valid  input  N_REQ  bit i: requester i has an operand.
- req_x  input  3*N_REQ  requester i operand at [3*i +: 3]; bit 2 = x1, bit 1 = x2, bit 0 = x3.
- req_ready  output  N_REQ  bit i: requester i granted this cycle; combinational, one-hot or zero.
- rsp_valid  output  1  result slot full.
- rsp_id  output  ID_W  index of the granted requester.
- rsp_f  output  1  f of that requester's operand.
- rsp_ready  input  1  consumer accepts the result.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - rsp_valid=0, rsp_id=0, rsp_f=0, round-robin pointer ptr=0; req_ready=0 while reset is asserted.
  - A pending result is discarded.
  - Reset is released synchronously to clk by the environment.
- Output slot is a 2-state FSM:
  - EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - can_accept = EMPTY | (FULL & rsp_ready).
- Arbitration, combinational:
  - If can_accept and any req_valid, the winner w is the first i with req_valid[i]=1, searching ptr, ptr+1, ..., wrapping N_REQ-1 -> 0.
  - req_ready[w]=1; all other bits 0.
  - If not can_accept, req_ready=0.
- On a clock edge with a grant:
  - rsp_valid<=1, rsp_id<=w, rsp_f<=f(req_x[w]).
  - ptr<=(w==N_REQ-1)?0:w+1.
  - Latency from grant to rsp_valid is 1 cycle.
- On an edge with no grant:
  - FULL & rsp_ready -> EMPTY (rsp_valid<=0); rsp_id and rsp_f hold their last values.
  - FULL & !rsp_ready -> hold; rsp_id and rsp_f stay stable.
  - ptr is unchanged.
- Simultaneous drain and grant (FULL & rsp_ready & a request): back-to-back, stays FULL with the new result. Sustained throughput is 1 result/cycle.
- Requesters hold req_valid and req_x stable until req_ready. req_x is sampled only in the grant cycle. A requester dropping valid before grant is allowed and is not an error.
- Fairness: with all requesters continuously valid and rsp_ready=1, the grant order is 0,1,...,N_REQ-1,0,...
- A requester waits at most N_REQ-1 grants once asserted.
- No combinational path from req_valid/req_x to rsp_*. rsp_ready -> req_ready is combinational.

Optional Feature:
- MUX_ARB_STATS_EN defined:
  - Adds output port eval_cnt [15:0].
  - Counts accepted results (rsp_valid & rsp_ready at an edge).
  - Saturates at 16'hFFFF; reset value 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package mux_eval_pkg:
  - Function f_eval(x1,x2,x3), single source of the Boolean equation.
  - Constant MAX_REQ=16 and STATS_W=16.
  - Typedef for the operand triple.
- One sub-module, mux_eval: purely combinational 3-in/1-out, instantiated once on the muxed winner operand.
- Arbiter pointer, FSM and output register live in mux_eval_arbiter.

Test Plan:
- Reset mid-FULL: assert rst_n=0 while rsp_valid=1 -> next sample rsp_valid=0, rsp_id=0, rsp_f=0. After release, first grant to lowest valid index >= 0.
- Exhaustive operands: requester 0 alone, rsp_ready=1, req_x=0..7 -> rsp_f sequence 0,1,0,0,0,1,1,1, each one cycle after grant.
- Round-robin, N_REQ=4: all four valid continuously, rsp_ready=1 -> req_ready one-hot 0001,0010,0100,1000,0001; rsp_id 0,1,2,3,0.
- Backpressure: rsp_ready=0 for 3 cycles with result FULL (id=2, f=1) -> req_ready=0, outputs stable 3 cycles. rsp_ready=1 -> same-cycle grant to next requester (id 3), back-to-back.
- Sparse wrap, N_REQ=3: ptr=2, only requesters 0 and 1 valid -> grant 0 then 1; ptr ends at 2.
- Stats (MUX_ARB_STATS_EN): 5 accepted results, 2 stalled cycles -> eval_cnt=5. Force 65540 accepts -> eval_cnt=16'hFFFF.

Source files
------------

// File: rtl/mux_eval_pkg.sv
// Shared types and the single definition of the evaluated Boolean function
// f = (x1 & x2) | (~x2 & x3), used by the mux_eval_arbiter slice.
package mux_eval_pkg;

  localparam int MAX_REQ = 16;
  localparam int STATS_W = 16;

  typedef struct packed {
    logic x1;
    logic x2;
    logic x3;
  } operand_t;

  function automatic logic f_eval(input logic x1, input logic x2, input logic x3);
    return (x1 & x2) | (~x2 & x3);
  endfunction

endpackage

// File: rtl/mux_eval.sv
// Purely combinational evaluator: one shared copy of the gate network,
// fed with the operand of whichever requester won arbitration.
module mux_eval
  import mux_eval_pkg::*;
(
  input  operand_t i_op,
  output logic     o_f
);

  assign o_f = f_eval(i_op.x1, i_op.x2, i_op.x3);

endmodule

// File: rtl/mux_eval_arbiter.sv
// Round-robin arbiter sharing one mux_eval among N_REQ requesters, with a
// one-entry registered result slot. Define MUX_ARB_STATS_EN to add eval_cnt.
//
// state    | meaning
// ST_EMPTY | result slot empty, rsp_valid=0
// ST_FULL  | result slot holds a result, rsp_valid=1
module mux_eval_arbiter
  import mux_eval_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [3*N_REQ-1:0] req_x,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  output logic [ID_W-1:0]    rsp_id,
  output logic               rsp_f,
  input  logic               rsp_ready
`ifdef MUX_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0] eval_cnt
`endif
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t          r_state;
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] r_rsp_id;
  logic            r_rsp_f;

  logic            w_can_accept;
  logic            w_found;
  logic            w_grant;
  logic [ID_W-1:0] w_win;
  operand_t        w_op;
  logic            w_f;
  int              idx;

  // rst_n gates acceptance so no requester sees ready while reset is held
  assign w_can_accept = rst_n & ((r_state == ST_EMPTY) | rsp_ready);

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_op    = '0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_win   = ID_W'(idx);
        w_op    = operand_t'(req_x[3*idx +: 3]);
      end
    end
  end

  assign w_grant = w_can_accept & w_found;

  always_comb begin
    req_ready = '0;
    if (w_grant) req_ready[w_win] = 1'b1;
  end

  mux_eval u_eval (
    .i_op (w_op),
    .o_f  (w_f)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_EMPTY;
      r_ptr    <= '0;
      r_rsp_id <= '0;
      r_rsp_f  <= 1'b0;
    end else if (w_grant) begin
      r_state  <= ST_FULL;
      r_rsp_id <= w_win;
      r_rsp_f  <= w_f;
      r_ptr    <= (w_win == ID_W'(N_REQ - 1)) ? '0 : w_win + 1'b1;
    end else if (r_state == ST_FULL && rsp_ready) begin
      r_state <= ST_EMPTY;
    end
  end

  assign rsp_valid = (r_state == ST_FULL);
  assign rsp_id    = r_rsp_id;
  assign rsp_f     = r_rsp_f;

`ifdef MUX_ARB_STATS_EN
  logic [STATS_W-1:0] r_eval_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_eval_cnt <= '0;
    end else if (rsp_valid && rsp_ready && (r_eval_cnt != {STATS_W{1'b1}})) begin
      r_eval_cnt <= r_eval_cnt + 1'b1;
    end
  end

  assign eval_cnt = r_eval_cnt;
`endif

endmodule

// File: tb/tb_mux_eval_arbiter.sv
// Directed, table-driven bench for mux_eval_arbiter (N_REQ=4 and N_REQ=3).
module tb_mux_eval_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [11:0] req_x;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic        rsp_f;
  logic        rsp_ready;

  logic [2:0]  req_valid3;
  logic [8:0]  req_x3;
  logic [2:0]  req_ready3;
  logic        rsp_valid3;
  logic [1:0]  rsp_id3;
  logic        rsp_f3;
  logic        rsp_ready3;

`ifdef MUX_ARB_STATS_EN
  logic [15:0] eval_cnt;
  logic [15:0] eval_cnt3;
`endif

  int n_pass  = 0;
  int n_total = 0;

  mux_eval_arbiter #(.N_REQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_f     (rsp_f),
    .rsp_ready (rsp_ready)
`ifdef MUX_ARB_STATS_EN
    ,
    .eval_cnt  (eval_cnt)
`endif
  );

  mux_eval_arbiter #(.N_REQ(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid3),
    .req_x     (req_x3),
    .req_ready (req_ready3),
    .rsp_valid (rsp_valid3),
    .rsp_id    (rsp_id3),
    .rsp_f     (rsp_f3),
    .rsp_ready (rsp_ready3)
`ifdef MUX_ARB_STATS_EN
    ,
    .eval_cnt  (eval_cnt3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0] x;
    logic       f;
  } op_vec_t;

  typedef struct {
    logic [3:0] ready;
    logic [1:0] id;
    logic       f;
  } rr_vec_t;

  op_vec_t op_tbl[8];
  rr_vec_t rr_tbl[5];

  initial begin
    // f truth table, hand-derived from (x1&x2)|(~x2&x3)
    op_tbl[0] = '{3'd0, 1'b0};
    op_tbl[1] = '{3'd1, 1'b1};
    op_tbl[2] = '{3'd2, 1'b0};
    op_tbl[3] = '{3'd3, 1'b0};
    op_tbl[4] = '{3'd4, 1'b0};
    op_tbl[5] = '{3'd5, 1'b1};
    op_tbl[6] = '{3'd6, 1'b1};
    op_tbl[7] = '{3'd7, 1'b1};
    // operands: req0=1 (f1), req1=0 (f0), req2=5 (f1), req3=2 (f0)
    rr_tbl[0] = '{4'b0001, 2'd0, 1'b1};
    rr_tbl[1] = '{4'b0010, 2'd1, 1'b0};
    rr_tbl[2] = '{4'b0100, 2'd2, 1'b1};
    rr_tbl[3] = '{4'b1000, 2'd3, 1'b0};
    rr_tbl[4] = '{4'b0001, 2'd0, 1'b1};

    rst_n      = 1'b0;
    req_valid  = 4'hF;
    req_x      = '0;
    rsp_ready  = 1'b1;
    req_valid3 = '0;
    req_x3     = '0;
    rsp_ready3 = 1'b1;
    step();
    step();
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_id",    32'(rsp_id),    32'd0);
    check("reset_rsp_f",     32'(rsp_f),     32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    rst_n     = 1'b1;
    step();

    // exhaustive operands on requester 0
    req_valid = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      req_x[2:0] = op_tbl[i].x;
      #1;
      check("op_req_ready", 32'(req_ready), 32'h1);
      step();
      check("op_rsp_valid", 32'(rsp_valid), 32'd1);
      check("op_rsp_id",    32'(rsp_id),    32'd0);
      check("op_rsp_f",     32'(rsp_f),     32'(op_tbl[i].f));
    end

    // hold FULL, then reset asynchronously mid-cycle
    req_valid = '0;
    rsp_ready = 1'b0;
    step();
    check("full_before_reset", 32'(rsp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midreset_rsp_id",    32'(rsp_id),    32'd0);
    check("midreset_rsp_f",     32'(rsp_f),     32'd0);
    step();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b0110;
    #1;
    check("post_reset_first_grant", 32'(req_ready), 32'b0010);

    // round robin, all valid
    req_valid = 4'hF;
    req_x     = {3'd2, 3'd5, 3'd0, 3'd1};
    for (int i = 0; i < 5; i++) begin
      #1;
      check("rr_req_ready", 32'(req_ready), 32'(rr_tbl[i].ready));
      step();
      check("rr_rsp_id", 32'(rsp_id), 32'(rr_tbl[i].id));
      check("rr_rsp_f",  32'(rsp_f),  32'(rr_tbl[i].f));
    end

    // advance to FULL with id=2, f=1, then stall 3 cycles
    step();
    step();
    check("bp_setup_id", 32'(rsp_id), 32'd2);
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_req_ready", 32'(req_ready), 32'd0);
      step();
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_id",    32'(rsp_id),    32'd2);
      check("bp_rsp_f",     32'(rsp_f),     32'd1);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(req_ready), 32'b1000);
    step();
    check("b2b_rsp_valid", 32'(rsp_valid), 32'd1);
    check("b2b_rsp_id",    32'(rsp_id),    32'd3);
    check("b2b_rsp_f",     32'(rsp_f),     32'd0);
    req_valid = '0;
    step();
    check("drain_rsp_valid", 32'(rsp_valid), 32'd0);
    check("drain_id_hold",   32'(rsp_id),    32'd3);
    check("drain_f_hold",    32'(rsp_f),     32'd0);

    // N_REQ=3 sparse wrap: grant 1 to put ptr at 2
    req_x3     = {3'd7, 3'd1, 3'd4};
    req_valid3 = 3'b010;
    #1;
    check("n3_setup_ready", 32'(req_ready3), 32'b010);
    step();
    req_valid3 = 3'b011;
    #1;
    check("n3_wrap_ready0", 32'(req_ready3), 32'b001);
    step();
    check("n3_wrap_id0", 32'(rsp_id3), 32'd0);
    check("n3_wrap_f0",  32'(rsp_f3),  32'd0);
    #1;
    check("n3_wrap_ready1", 32'(req_ready3), 32'b010);
    step();
    check("n3_wrap_id1", 32'(rsp_id3), 32'd1);
    check("n3_wrap_f1",  32'(rsp_f3),  32'd1);
    req_valid3 = 3'b111;
    #1;
    check("n3_ptr_at_2", 32'(req_ready3), 32'b100);
    req_valid3 = '0;
    step();

`ifdef MUX_ARB_STATS_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("stats_reset", 32'(eval_cnt), 32'd0);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    step();
    step();
    rsp_ready = 1'b1;
    step();
    step();
    step();
    step();
    req_valid = '0;
    step();
    step();
    check("stats_count5", 32'(eval_cnt), 32'd5);
    req_valid = 4'b0001;
    for (int i = 0; i < 65540; i++) step();
    check("stats_saturate", 32'(eval_cnt), 32'hFFFF);
    req_valid = '0;
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
